pulse_sync_arbiter: RTL and testbench



---
 rtl/pulse_sync_arbiter_if.sv | 25 ++
 rtl/pulse_sync_arbiter.sv | 106 ++++++++++
 tb/tb_pulse_sync_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_sync_arbiter_if.sv
// Request/grant bundle between source-domain requesters and the pulse
// synchronizer arbiter.
interface pulse_sync_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) ();
  logic [N_REQ-1:0] req_pulse;
  logic             clr_overflow;
  logic             sig_pulse_source;
  logic [ID_W-1:0]  sel_id;
  logic [N_REQ-1:0] ack;
  logic [N_REQ-1:0] pending;
  logic             busy;
  logic [N_REQ-1:0] overflow;

  modport master (
    output req_pulse, clr_overflow,
    input  sig_pulse_source, sel_id, ack, pending, busy, overflow
  );

  modport slave (
    input  req_pulse, clr_overflow,
    output sig_pulse_source, sel_id, ack, pending, busy, overflow
  );
endinterface

// File: rtl/pulse_sync_arbiter.sv
// Round-robin scheduler sharing one slow-to-fast pulse synchronizer among N_REQ
// requesters, with a GAP-cycle guard after every issued pulse.
module pulse_sync_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned GAP   = 4,
  parameter int unsigned ID_W  = 2
) (
  input logic                clk_source,
  input logic                rst_source,
  pulse_sync_arbiter_if.slave bus
);
  localparam int unsigned CntW = $clog2(GAP + 1);

  typedef enum logic {StIdle, StHold} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [ID_W-1:0]  last_q;
  logic [ID_W-1:0]  sel_q;
  logic [N_REQ-1:0] pending_q;
  logic [N_REQ-1:0] overflow_q;
  logic [N_REQ-1:0] ack_q;
  logic             sig_q;
  logic             busy_q;

  logic             grant_vld;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W-1:0]  cand;
  logic             issue;
  logic [N_REQ-1:0] grant_oh;
  logic [N_REQ-1:0] ovf_set;
  logic [N_REQ-1:0] pending_d;
  logic [N_REQ-1:0] overflow_d;

  // First pending requester after last_q, wrapping modulo N_REQ.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      cand = ID_W'((32'(last_q) + off) % N_REQ);
      if (!grant_vld && pending_q[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    issue    = (state_q == StIdle) && grant_vld;
    grant_oh = issue ? (N_REQ'(1) << grant_idx) : '0;
    // A request landing on the grant edge of its own requester re-arms pending
    // without counting as an overflow.
    ovf_set    = bus.req_pulse & pending_q & ~grant_oh;
    pending_d  = (pending_q & ~grant_oh) | bus.req_pulse;
    overflow_d = (bus.clr_overflow ? '0 : overflow_q) | ovf_set;
  end

  always_ff @(posedge clk_source) begin
    if (rst_source) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      last_q     <= ID_W'(N_REQ - 1);
      sel_q      <= '0;
      pending_q  <= '0;
      overflow_q <= '0;
      ack_q      <= '0;
      sig_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      sig_q      <= 1'b0;
      ack_q      <= '0;
      unique case (state_q)
        StIdle: begin
          if (issue) begin
            sig_q   <= 1'b1;
            ack_q   <= grant_oh;
            sel_q   <= grant_idx;
            last_q  <= grant_idx;
            cnt_q   <= CntW'(GAP);
            busy_q  <= 1'b1;
            state_q <= StHold;
          end
        end
        StHold: begin
          if (cnt_q == CntW'(1)) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.sig_pulse_source = sig_q;
  assign bus.sel_id           = sel_q;
  assign bus.ack              = ack_q;
  assign bus.pending          = pending_q;
  assign bus.busy             = busy_q;
  assign bus.overflow         = overflow_q;
endmodule

// File: tb/tb_pulse_sync_arbiter.sv
// Scoreboard bench: stimulus pushes expected (id, cycle) grants, a negedge
// monitor pops and checks every issued pulse.
module tb_pulse_sync_arbiter;
  localparam int unsigned NReq = 4;
  localparam int unsigned Gap  = 4;
  localparam int unsigned IdW  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   exp_id[$];
  int   exp_cyc[$];
  int   mon_id;
  int   mon_t;
  logic prev_pulse = 1'b0;

  pulse_sync_arbiter_if #(.N_REQ(NReq), .ID_W(IdW)) bus ();

  pulse_sync_arbiter #(.N_REQ(NReq), .GAP(Gap), .ID_W(IdW)) dut (
    .clk_source (clk),
    .rst_source (rst),
    .bus        (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at cyc %0d", name, got, exp, cyc);
    end
  endtask

  // Monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.sig_pulse_source) begin
      chk("pulse_back_to_back", int'(prev_pulse), 0);
      chk("pulse_expected", int'(exp_id.size() > 0), 1);
      if (exp_id.size() > 0) begin
        mon_id = exp_id.pop_front();
        mon_t  = exp_cyc.pop_front();
        chk("grant_id", int'(bus.sel_id), mon_id);
        chk("grant_ack", int'(bus.ack), 1 << mon_id);
        chk("grant_cyc", cyc, mon_t);
      end
    end else begin
      chk("ack_idle", int'(bus.ack), 0);
    end
    prev_pulse = bus.sig_pulse_source;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic expect_pulse(input int id, input int t);
    exp_id.push_back(id);
    exp_cyc.push_back(t);
  endtask

  task automatic all_zero(input string name);
    chk(name, int'({bus.sig_pulse_source, bus.ack, bus.sel_id, bus.pending, bus.busy,
                    bus.overflow}), 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bus.busy || bus.pending != '0) && n < 100) begin
      step();
      n++;
    end
    chk("wait_idle_timeout", int'(n < 100), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    all_zero("reset_clear");
    rst = 1'b0;
  endtask

  task automatic clear_overflow();
    bus.clr_overflow = 1'b1;
    step();
    bus.clr_overflow = 1'b0;
    chk("overflow_clr", int'(bus.overflow), 0);
  endtask

  int c;

  initial begin
    bus.req_pulse    = '0;
    bus.clr_overflow = 1'b0;

    // Reset holds everything at 0.
    repeat (10) begin
      step();
      all_zero("reset_outputs");
    end
    rst = 1'b0;
    step();

    // Single request, idle arbiter.
    c = cyc;
    expect_pulse(2, c + 2);
    bus.req_pulse = 4'b0100;
    step();
    bus.req_pulse = '0;
    chk("single_pending", int'(bus.pending), 4'b0100);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("busy_len", int'(bus.busy), int'(i < 4));
      step();
    end
    chk("sel_hold", int'(bus.sel_id), 2);

    // All four at once from reset: 0,1,2,3 five cycles apart.
    do_reset();
    c = cyc;
    for (int i = 0; i < 4; i++) expect_pulse(i, c + 2 + 5 * i);
    bus.req_pulse = 4'b1111;
    step();
    bus.req_pulse = '0;
    chk("drain_1111", int'(bus.pending), 4'b1111);
    step();
    chk("drain_1110", int'(bus.pending), 4'b1110);
    repeat (5) step();
    chk("drain_1100", int'(bus.pending), 4'b1100);
    repeat (5) step();
    chk("drain_1000", int'(bus.pending), 4'b1000);
    repeat (5) step();
    chk("drain_0000", int'(bus.pending), 4'b0000);
    wait_idle();

    // Fairness: grant 1, then hold requests 0 and 1 high.
    c = cyc;
    expect_pulse(1, c + 2);
    bus.req_pulse = 4'b0010;
    step();
    bus.req_pulse = '0;
    wait_idle();
    c = cyc;
    for (int i = 0; i < 6; i++) expect_pulse(i % 2, c + 2 + 5 * i);
    bus.req_pulse = 4'b0011;
    repeat (17) step();
    bus.req_pulse = '0;
    wait_idle();
    chk("fair_overflow", int'(bus.overflow), 4'b0011);
    clear_overflow();

    // Overflow: two requests for 3 while busy.
    c = cyc;
    expect_pulse(0, c + 2);
    expect_pulse(3, c + 7);
    bus.req_pulse = 4'b0001;
    step();
    bus.req_pulse = '0;
    step();
    bus.req_pulse = 4'b1000;
    repeat (2) step();
    bus.req_pulse = '0;
    step();
    chk("ovf_set", int'(bus.overflow), 4'b1000);
    chk("ovf_busy", int'(bus.busy), 1);
    wait_idle();
    chk("ovf_sticky", int'(bus.overflow), 4'b1000);
    clear_overflow();

    // Clear coinciding with a fresh overflow on 3; overflow on 1 clears.
    c = cyc;
    expect_pulse(0, c + 2);
    expect_pulse(1, c + 7);
    expect_pulse(3, c + 12);
    bus.req_pulse = 4'b0001;
    step();
    bus.req_pulse = '0;
    step();
    bus.req_pulse = 4'b1010;
    repeat (2) step();
    chk("ovf_pre_clr", int'(bus.overflow), 4'b1010);
    bus.req_pulse    = 4'b1000;
    bus.clr_overflow = 1'b1;
    step();
    bus.req_pulse    = '0;
    bus.clr_overflow = 1'b0;
    chk("ovf_set_wins", int'(bus.overflow), 4'b1000);
    wait_idle();
    clear_overflow();

    // Request on the grant edge of the same requester.
    c = cyc;
    expect_pulse(0, c + 2);
    expect_pulse(0, c + 7);
    bus.req_pulse = 4'b0001;
    repeat (2) step();
    bus.req_pulse = '0;
    chk("collision_pending", int'(bus.pending), 4'b0001);
    chk("collision_no_ovf", int'(bus.overflow), 0);
    wait_idle();
    chk("collision_no_ovf_end", int'(bus.overflow), 0);

    // Reset two cycles into HOLD with 1 and 2 pending.
    c = cyc;
    expect_pulse(0, c + 2);
    bus.req_pulse = 4'b0001;
    step();
    bus.req_pulse = '0;
    step();
    bus.req_pulse = 4'b0110;
    step();
    bus.req_pulse = '0;
    chk("hold_pending", int'(bus.pending), 4'b0110);
    chk("hold_busy", int'(bus.busy), 1);
    rst = 1'b1;
    step();
    all_zero("reset_mid_hold");
    rst = 1'b0;
    repeat (15) begin
      step();
      chk("no_reissue", int'(bus.pending), 0);
    end
    c = cyc;
    expect_pulse(1, c + 2);
    bus.req_pulse = 4'b0010;
    step();
    bus.req_pulse = '0;
    wait_idle();

    repeat (3) step();
    chk("scoreboard_empty", exp_id.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
